// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF (push side) and decode (pop side) around fetch_queue.
interface fetch_queue_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
);
  logic               push_valid;
  logic [PC_W-1:0]    push_pc;
  logic [INSTR_W-1:0] push_instr;
  logic               push_ready;
  logic               pop_valid;
  logic [PC_W-1:0]    pop_pc;
  logic [INSTR_W-1:0] pop_instr;
  logic               pop_ready;

  modport master (
    output push_valid, push_pc, push_instr, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr
  );

  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} buffer between IF and decode with flush on taken branch.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  fetch_queue_if.slave             fq,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push_fire, pop_fire;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic          bypass;
`endif

  always_comb begin
    full          = (count_q == DEPTH_C);
    empty         = (count_q == '0);
    fq.push_ready = !full;
`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming pair; it is stored only if decode stalls.
    bypass        = empty && fq.push_valid && !flush && !reset;
    fq.pop_valid  = !empty || bypass;
    {fq.pop_pc, fq.pop_instr} = bypass ? {fq.push_pc, fq.push_instr} : mem_q[rd_ptr_q];
    push_fire     = fq.push_valid && !full && !(bypass && fq.pop_ready);
    pop_fire      = !empty && fq.pop_ready;
`else
    fq.pop_valid  = !empty;
    {fq.pop_pc, fq.pop_instr} = mem_q[rd_ptr_q];
    push_fire     = fq.push_valid && !full;
    pop_fire      = !empty && fq.pop_ready;
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push_fire && !reset && !flush) mem_q[wr_ptr_q] <= {fq.push_pc, fq.push_instr};
  end

  assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_W = 8;
  localparam int INSTR_W = 9;

  logic clk = 1'b0;
  logic reset, flush;
  logic [$clog2(DEPTH):0] count;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [PC_W+INSTR_W-1:0] mq [$];

  fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .fq    (fq.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit bypass_now(int n);
`ifdef FETCH_QUEUE_BYPASS_EN
    return (n == 0) && fq.push_valid && !flush && !reset;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the queue contents after each edge.
  always @(posedge clk) begin
    int n;
    bit do_push, do_pop;
    n = mq.size();
    if (reset || flush) begin
      mq.delete();
    end else if (bypass_now(n)) begin
      if (!fq.pop_ready) mq.push_back({fq.push_pc, fq.push_instr});
    end else begin
      do_pop  = (n != 0) && fq.pop_ready;
      do_push = fq.push_valid && (n != DEPTH);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({fq.push_pc, fq.push_instr});
    end
  end

  always @(negedge clk) begin
    int n;
    bit exp_pv;
    logic [PC_W+INSTR_W-1:0] exp_data;
    if (chk_en) begin
      n = mq.size();
      exp_pv = (n != 0) || bypass_now(n);
      chk("count", 32'(count), 32'(n));
      chk("push_ready", 32'(fq.push_ready), 32'(n != DEPTH));
      chk("pop_valid", 32'(fq.pop_valid), 32'(exp_pv));
      if (exp_pv) begin
        exp_data = (n != 0) ? mq[0] : {fq.push_pc, fq.push_instr};
        chk("pop_data", 32'({fq.pop_pc, fq.pop_instr}), 32'(exp_data));
      end
    end
  end

  task automatic push_set(input bit v, input logic [PC_W-1:0] pc);
    fq.push_valid = v;
    fq.push_pc    = pc;
    fq.push_instr = INSTR_W'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    fq.pop_ready = 1'b0;
    push_set(1'b0, '0);
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_pop_valid", 32'(fq.pop_valid), 0);
    chk("rst_push_ready", 32'(fq.push_ready), 1);

    // Fill to DEPTH, then an extra push must be ignored.
    for (int i = 0; i < 5; i++) begin
      push_set(1'b1, PC_W'(i));
      cyc();
    end
    push_set(1'b0, '0);
    #1;
    chk("full_count", 32'(count), 4);
    chk("full_push_ready", 32'(fq.push_ready), 0);

    fq.pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc", 32'(fq.pop_pc), 32'(i));
      cyc();
    end
    #1;
    chk("drain_empty", 32'(fq.pop_valid), 0);

    // Streaming push+pop with wraparound.
    for (int i = 0; i < 10; i++) begin
      push_set(1'b1, PC_W'(8'h10 + i));
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("stream_pc", 32'(fq.pop_pc), 32'(8'h10 + i));
`else
      if (i > 0) chk("stream_pc", 32'(fq.pop_pc), 32'(8'h10 + i - 1));
`endif
      cyc();
    end
    push_set(1'b0, '0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("stream_count", 32'(count), 0);
`else
    chk("stream_count", 32'(count), 1);
`endif
    cyc();

    // Flush with a concurrent push discards everything.
    fq.pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_set(1'b1, PC_W'(8'h30 + i));
      cyc();
    end
    flush = 1'b1;
    push_set(1'b1, 8'hAA);
    cyc();
    flush = 1'b0;
    push_set(1'b0, '0);
    #1;
    chk("flush_count", 32'(count), 0);
    chk("flush_pop_valid", 32'(fq.pop_valid), 0);

    // Reset mid-stream: the first push afterwards becomes the head.
    for (int i = 0; i < 2; i++) begin
      push_set(1'b1, PC_W'(8'h40 + i));
      cyc();
    end
    push_set(1'b0, '0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    push_set(1'b1, 8'h20);
    cyc();
    push_set(1'b0, '0);
    #1;
    chk("rst_mid_count", 32'(count), 1);
    chk("rst_mid_pc", 32'(fq.pop_pc), 32'h20);

    // Randomized traffic with phases biased towards filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 100) % 3;
      push_set(($urandom_range(3, 0) != 0), PC_W'($urandom));
      case (phase)
        0:       fq.pop_ready = ($urandom_range(3, 0) == 0);
        1:       fq.pop_ready = ($urandom_range(3, 0) != 0);
        default: fq.pop_ready = $urandom_range(1, 0) == 1;
      endcase
      flush = ($urandom_range(39, 0) == 0);
      reset = ($urandom_range(79, 0) == 0);
      cyc();
    end
    flush = 1'b0;
    reset = 1'b0;
    push_set(1'b0, '0);
    cyc();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
